// File: rtl/dac_stream_scaler.sv
// Signed gain/offset scaler for multi-lane DAC beats with round-half-up and saturation.
// Includes a 2-entry input skid buffer and a sticky count of clamped samples.
module dac_stream_scaler #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int DAC_DATA_WIDTH  = 16,
    parameter int GAIN_WIDTH      = 18,
    parameter int GAIN_FRAC       = 16,
    parameter int SAT_COUNT_WIDTH = 16
) (
    input  logic                       axis_CLK,
    input  logic                       axis_RESET,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_TDATA,
    input  logic                       s_axis_TVALID,
    output logic                       s_axis_TREADY,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_TDATA,
    output logic                       m_axis_TVALID,
    input  logic                       m_axis_TREADY,
    input  logic                       coefStrobe,
    input  logic [GAIN_WIDTH-1:0]      gainIn,
    input  logic [DAC_DATA_WIDTH-1:0]  offsetIn,
    input  logic                       satCountClear,
    output logic [SAT_COUNT_WIDTH-1:0] satCount
);
    localparam int SAMPLES = AXIS_DATA_WIDTH / DAC_DATA_WIDTH;
    localparam int PW      = DAC_DATA_WIDTH + GAIN_WIDTH;
    localparam int TW      = PW + 2;
    localparam int IW      = $clog2(SAMPLES + 1);
    localparam logic signed [GAIN_WIDTH-1:0] GAIN_ONE   = GAIN_WIDTH'(1) << GAIN_FRAC;
    localparam logic signed [TW-1:0]         ROUND_HALF = TW'(1) << (GAIN_FRAC - 1);
    localparam logic signed [TW-1:0]         SAMPLE_MAX = TW'((1 << (DAC_DATA_WIDTH - 1)) - 1);
    localparam logic signed [TW-1:0]         SAMPLE_MIN = ~SAMPLE_MAX;

    logic signed [GAIN_WIDTH-1:0]     gain_q;
    logic signed [DAC_DATA_WIDTH-1:0] offset_q;
    logic [AXIS_DATA_WIDTH-1:0]       skid_q [2];
    logic                             wr_ptr_q, rd_ptr_q, ready_q;
    logic [1:0]                       count_q, count_d;
    logic                             push_s, pop_s;
    logic                             en1_s, en2r_s, en2t_s, en3_s;
    logic                             v1_q, v2r_q, v2t_q, v3_q;
    logic signed [PW-1:0]             prod_s [SAMPLES];
    logic signed [PW-1:0]             p1_q   [SAMPLES];
    logic signed [TW-1:0]             round_s [SAMPLES];
    logic signed [TW-1:0]             r2_q    [SAMPLES];
    logic signed [TW-1:0]             sum_s   [SAMPLES];
    logic signed [TW-1:0]             t3_q    [SAMPLES];
    logic signed [DAC_DATA_WIDTH-1:0] off1_q, off2_q;
    logic [AXIS_DATA_WIDTH-1:0]       clamp_s, out_q;
    logic [IW-1:0]                    sat_inc_s;
    logic [SAT_COUNT_WIDTH-1:0]       sat_q, sat_d, sat_base_s;
    logic [SAT_COUNT_WIDTH:0]         sat_sum_s;

    // Stage enables: a stage advances when its successor is empty or advancing.
    assign en3_s  = !v3_q || m_axis_TREADY;
    assign en2t_s = !v2t_q || en3_s;
    assign en2r_s = !v2r_q || en2t_s;
    assign en1_s  = !v1_q || en2r_s;
    assign push_s = s_axis_TVALID && ready_q;
    assign pop_s  = (count_q != 2'd0) && en1_s;

    // Active coefficient pair.
    always_ff @(posedge axis_CLK) begin
        if (axis_RESET) begin
            gain_q   <= GAIN_ONE;
            offset_q <= '0;
        end else if (coefStrobe) begin
            gain_q   <= gainIn;
            offset_q <= offsetIn;
        end
    end

    // Skid occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Skid pointers, occupancy and registered upstream ready.
    always_ff @(posedge axis_CLK) begin
        if (axis_RESET) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push_s) wr_ptr_q <= ~wr_ptr_q;
            if (pop_s)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

    // Skid storage.
    always_ff @(posedge axis_CLK) begin
        if (push_s) skid_q[wr_ptr_q] <= s_axis_TDATA;
    end

    // Datapath arithmetic; widths are wide enough that nothing wraps before the clamp.
    always_comb begin
        for (int k = 0; k < SAMPLES; k++) begin
            prod_s[k]  = PW'($signed(skid_q[rd_ptr_q][k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH])) * PW'(gain_q);
            round_s[k] = (TW'(p1_q[k]) + ROUND_HALF) >>> GAIN_FRAC;
            sum_s[k]   = r2_q[k] + TW'(off2_q);
        end
    end

    // Clamp each lane and count how many were clamped.
    always_comb begin
        clamp_s   = '0;
        sat_inc_s = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            if (t3_q[k] > SAMPLE_MAX) begin
                clamp_s[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = SAMPLE_MAX[DAC_DATA_WIDTH-1:0];
                sat_inc_s = sat_inc_s + IW'(1);
            end else if (t3_q[k] < SAMPLE_MIN) begin
                clamp_s[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = SAMPLE_MIN[DAC_DATA_WIDTH-1:0];
                sat_inc_s = sat_inc_s + IW'(1);
            end else begin
                clamp_s[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = t3_q[k][DAC_DATA_WIDTH-1:0];
            end
        end
    end

    // Pipeline valid bits.
    always_ff @(posedge axis_CLK) begin
        if (axis_RESET) begin
            v1_q  <= 1'b0;
            v2r_q <= 1'b0;
            v2t_q <= 1'b0;
            v3_q  <= 1'b0;
        end else begin
            if (en1_s)  v1_q  <= pop_s;
            if (en2r_s) v2r_q <= v1_q;
            if (en2t_s) v2t_q <= v2r_q;
            if (en3_s)  v3_q  <= v2t_q;
        end
    end

    // Offset travels with each beat so a later strobe cannot touch beats already past S1.
    always_ff @(posedge axis_CLK) begin
        if (en1_s) begin
            p1_q   <= prod_s;
            off1_q <= offset_q;
        end
        if (en2r_s) begin
            r2_q   <= round_s;
            off2_q <= off1_q;
        end
        if (en2t_s) t3_q <= sum_s;
    end

    // Output register.
    always_ff @(posedge axis_CLK) begin
        if (axis_RESET)  out_q <= '0;
        else if (en3_s)  out_q <= clamp_s;
    end

    // Saturation counter: clear takes effect before a coincident increment; sticks at all-ones.
    always_comb begin
        sat_base_s = satCountClear ? '0 : sat_q;
        sat_sum_s  = {1'b0, sat_base_s} + (SAT_COUNT_WIDTH + 1)'(sat_inc_s);
        sat_d      = sat_base_s;
        if (en3_s && v2t_q) begin
            if (sat_sum_s[SAT_COUNT_WIDTH]) sat_d = '1;
            else                            sat_d = sat_sum_s[SAT_COUNT_WIDTH-1:0];
        end else begin
            sat_d = sat_base_s;
        end
    end

    // Saturation counter register.
    always_ff @(posedge axis_CLK) begin
        if (axis_RESET) sat_q <= '0;
        else            sat_q <= sat_d;
    end

    assign s_axis_TREADY = ready_q;
    assign m_axis_TVALID = v3_q;
    assign m_axis_TDATA  = out_q;
    assign satCount      = sat_q;
endmodule

// File: tb/tb_dac_stream_scaler.sv
// Randomized and directed bench for dac_stream_scaler, checked against an arithmetic
// per-beat reference model and an expected-beat queue.
module tb_dac_stream_scaler;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        coef_stb;
    logic [17:0] gain_in;
    logic [15:0] off_in;
    logic        sat_clr;
    logic [15:0] sat_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_cnt = 0;
    int          rdy_mode = 0;
    int          stall_from = -1000;
    int          m_gain = 65536;
    int          m_off  = 0;
    int          sat_model = 0;
    logic [31:0] exp_q [$];
    int          acc_edges [$];
    int          out_edges [$];

    dac_stream_scaler dut (
        .axis_CLK(clk), .axis_RESET(rst),
        .s_axis_TDATA(s_data), .s_axis_TVALID(s_valid), .s_axis_TREADY(s_ready),
        .m_axis_TDATA(m_data), .m_axis_TVALID(m_valid), .m_axis_TREADY(m_ready),
        .coefStrobe(coef_stb), .gainIn(gain_in), .offsetIn(off_in),
        .satCountClear(sat_clr), .satCount(sat_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_beat(input logic [31:0] d, input int g, input int o,
                                               output int nsat);
        logic [31:0] res;
        logic [15:0] lane;
        longint      s, t;
        res  = '0;
        nsat = 0;
        for (int k = 0; k < 2; k++) begin
            lane = d[k*16 +: 16];
            s = longint'($signed(lane));
            t = ((s * longint'(g) + 64'sd32768) >>> 16) + longint'(o);
            if (t > 64'sd32767) begin
                t = 64'sd32767;
                nsat++;
            end else if (t < -64'sd32768) begin
                t = -64'sd32768;
                nsat++;
            end
            res[k*16 +: 16] = t[15:0];
        end
        return res;
    endfunction

    // Sample the bus half a cycle before each edge: values seen here are the ones that edge uses.
    always @(negedge clk) begin
        int          ns;
        logic [31:0] e;
        if (rst) begin
            exp_q.delete();
            m_gain    = 65536;
            m_off     = 0;
            sat_model = 0;
        end else begin
            if (sat_clr) sat_model = 0;
            if (coef_stb) begin
                m_gain = int'($signed(gain_in));
                m_off  = int'($signed(off_in));
            end
            if (s_valid && s_ready) begin
                e = model_beat(s_data, m_gain, m_off, ns);
                exp_q.push_back(e);
                sat_model = (sat_model + ns > 65535) ? 65535 : sat_model + ns;
                acc_edges.push_back(edge_cnt + 1);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check_value("unexpected_beat", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                else                   check_value("beat_data", m_data, exp_q.pop_front());
                out_edges.push_back(edge_cnt);
            end
        end
    end

    // Downstream ready pattern generator.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((edge_cnt % 16) != 15) &&
                                   !(edge_cnt >= stall_from && edge_cnt < stall_from + 20);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send_beat(input logic [31:0] d);
        int   k;
        logic acc;
        k   = 0;
        acc = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        while (!acc && k < 2000) begin
            @(negedge clk);
            acc = s_ready && !rst;
            @(posedge clk); #1;
            k++;
        end
        s_valid = 1'b0;
        if (!acc) check_value("send_timeout", 0, 1);
    endtask

    task automatic set_coef(input logic [17:0] g, input logic [15:0] o);
        gain_in  = g;
        off_in   = o;
        coef_stb = 1'b1;
        @(posedge clk); #1;
        coef_stb = 1'b0;
    endtask

    task automatic clear_sat();
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || m_valid) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check_value({tag, "_drained"}, exp_q.size(), 0);
        check_value({tag, "_satcount"}, sat_cnt, sat_model);
    endtask

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        int a0, o0, k, n;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; coef_stb = 1'b0;
        gain_in = '0; off_in = '0; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_m_valid", m_valid, 0);
        check_value("rst_m_data", m_data, 0);
        check_value("rst_s_ready", s_ready, 0);
        check_value("rst_satcount", sat_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_value("ready_after_rst", s_ready, 1);
        @(posedge clk); #1;

        // Passthrough ramp, latency and one beat per clock.
        a0 = acc_edges.size();
        o0 = out_edges.size();
        for (int i = 0; i < 64; i++) send_beat({16'(2 * i + 1), 16'(2 * i)});
        drain("pass");
        check_value("pass_sat_zero", sat_cnt, 0);
        check_value("pass_out_count", out_edges.size() - o0, 64);
        if (out_edges.size() - o0 == 64 && acc_edges.size() - a0 == 64) begin
            check_value("pass_latency", out_edges[o0] - acc_edges[a0], 4);
            check_value("pass_in_rate", acc_edges[a0 + 63] - acc_edges[a0], 63);
            check_value("pass_out_rate", out_edges[o0 + 63] - out_edges[o0], 63);
        end

        // Rounding and offset.
        set_coef(18'h08000, 16'd0);
        send_beat({16'hFFFD, 16'h0003});
        drain("round");
        set_coef(18'h08000, 16'd100);
        send_beat({16'hFFFD, 16'h0003});
        drain("round_off");

        // Saturation, then clear coinciding with a saturated S3 load.
        set_coef(18'h18000, 16'd0);
        clear_sat();
        send_beat({16'h8AD0, 16'h7530});
        drain("sat");
        check_value("sat_count_2", sat_cnt, 2);
        send_beat({16'h8AD0, 16'h7530});
        repeat (3) @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        repeat (8) @(posedge clk); #1;
        check_value("sat_clear_coincide", sat_cnt, 2);
        clear_sat();
        check_value("sat_clear", sat_cnt, 0);

        // -2.0 gain boundary.
        set_coef(18'h20000, 16'd0);
        send_beat({16'h7FFF, 16'h8000});
        drain("neg2");

        // Backpressure: 1-in-16 drops plus a 20-cycle stall.
        set_coef(18'h10000, 16'd0);
        a0 = acc_edges.size();
        o0 = out_edges.size();
        stall_from = edge_cnt + 30;
        rdy_mode   = 1;
        fork
            for (int i = 0; i < 64; i++) send_beat({16'(2 * i + 1), 16'(2 * i)});
            begin
                repeat (stall_from + 19 - edge_cnt) @(posedge clk);
                @(negedge clk);
                check_value("stall_ready_low", s_ready, 0);
                n = 0;
                for (int i = a0; i < acc_edges.size(); i++)
                    if (acc_edges[i] > stall_from && acc_edges[i] <= stall_from + 20) n++;
                check_value("stall_accepts_le2", (n <= 2), 1);
            end
        join
        drain("bp");
        check_value("bp_out_count", out_edges.size() - o0, 64);

        // Coefficient change after beat 10.
        set_coef(18'h10000, 16'd0);
        a0 = acc_edges.size();
        fork
            for (int i = 0; i < 30; i++) send_beat({16'(-(200 * i + 51)), 16'(200 * i + 77)});
            begin
                k = 0;
                while (acc_edges.size() < a0 + 11 && k < 1000) begin
                    @(posedge clk); #1;
                    k++;
                end
                gain_in  = 18'h08000;
                off_in   = 16'd0;
                coef_stb = 1'b1;
                @(posedge clk); #1;
                coef_stb = 1'b0;
            end
        join
        drain("coef_mid");

        // Random coefficients, data, gaps and backpressure.
        for (int r = 0; r < 6; r++) begin
            set_coef(18'($urandom()), 16'($urandom_range(0, 3) == 0 ? $urandom() : $urandom_range(0, 255)));
            rdy_mode = 2;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 3) == 0)
                    for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                        @(posedge clk); #1;
                    end
                send_beat({rand_lane(), rand_lane()});
            end
            drain("rand");
        end

        // Counter saturation: 40000 beats of two clamped lanes.
        set_coef(18'h18000, 16'd0);
        clear_sat();
        for (int i = 0; i < 40000; i++) send_beat({16'h8AD0, 16'h7530});
        drain("sticky");
        check_value("sat_sticky", sat_cnt, 16'hFFFF);

        // Reset mid-stream with a strobe that must be ignored.
        set_coef(18'h08000, 16'd7);
        a0 = acc_edges.size();
        fork
            for (int i = 0; i < 20; i++) send_beat({16'(3 * i + 1001), 16'(3 * i + 1000)});
            begin
                k = 0;
                while (acc_edges.size() < a0 + 5 && k < 1000) begin
                    @(posedge clk); #1;
                    k++;
                end
                rst      = 1'b1;
                coef_stb = 1'b1;
                gain_in  = 18'h04000;
                off_in   = 16'd55;
                @(posedge clk); #1;
                coef_stb = 1'b0;
                @(negedge clk);
                check_value("mid_rst_m_valid", m_valid, 0);
                check_value("mid_rst_satcount", sat_cnt, 0);
                check_value("mid_rst_s_ready", s_ready, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_value("mid_rst_ready_back", s_ready, 1);
            end
        join
        drain("mid_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dac_stream_scaler.md
Name: dac_stream_scaler

Overview:
- AXI-Stream pipeline stage directly downstream of the DAC table streamer, between the streamer's axis output and the RF DAC sample interface.
- Applies a signed gain and offset to every DAC sample in each beat, with round-half-up and saturation.
- Absorbs DAC-side backpressure in a registered skid buffer.
- Counts saturated samples for diagnostics.

Parameters:
- AXIS_DATA_WIDTH, 32, stream beat width; an integer multiple of DAC_DATA_WIDTH.
- DAC_DATA_WIDTH, 16, signed two's-complement sample width.
- GAIN_WIDTH, 18, signed gain width.
- GAIN_FRAC, 16, fractional bits of gain (default range -2.0 to +2.0-2^-16).
- SAT_COUNT_WIDTH, 16, saturation counter width.

Ports:
- axis_CLK  input  1  sole clock; all logic synchronous to it.
- axis_RESET  input  1  synchronous, active-high reset.
- s_axis_TDATA  input  AXIS_DATA_WIDTH  upstream beat; lane k = bits [k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH]; lane 0 is the earliest sample.
- s_axis_TVALID  input  1  upstream valid.
- s_axis_TREADY  output  1  upstream ready, registered.
- m_axis_TDATA  output  AXIS_DATA_WIDTH  scaled beat, same lane order.
- m_axis_TVALID  output  1  downstream valid.
- m_axis_TREADY  input  1  downstream ready.
- coefStrobe  input  1  one-cycle pulse that loads gainIn/offsetIn.
- gainIn  input  GAIN_WIDTH  signed gain, Q(GAIN_WIDTH-GAIN_FRAC).GAIN_FRAC.
- offsetIn  input  DAC_DATA_WIDTH  signed offset in DAC LSBs.
- satCountClear  input  1  one-cycle pulse that clears satCount.
- satCount  output  SAT_COUNT_WIDTH  saturated-sample count, sticky at all-ones.

Behaviour:
- Interface: one clock (axis_CLK). Reset axis_RESET is synchronous and active-high.
- Reset values:
  - m_axis_TVALID=0, m_axis_TDATA=0, s_axis_TREADY=0 while axis_RESET is high; s_axis_TREADY=1 on the first edge after deassertion.
  - satCount=0, gain=1<<GAIN_FRAC (1.0), offset=0.
  - All pipeline valid bits cleared; in-flight beats are discarded.
- Handshakes:
  - A transfer occurs on an edge where TVALID&&TREADY.
  - m_axis_TDATA/TVALID hold stable while TVALID=1 and TREADY=0.
  - No beat is lost, duplicated or reordered under any TREADY pattern.
- Input skid buffer (2 entries):
  - s_axis_TREADY=1 when the skid buffer has at least one free entry, computed as a registered value.
  - With a continuous stream and m_axis_TREADY=1, throughput is one beat per clock.
- Pipeline (each stage enabled when its successor is empty or advancing; bubbles collapse):
  - S1: p_k = lane_k * gain (signed, DAC_DATA_WIDTH+GAIN_WIDTH bits).
  - S2: r_k = (p_k + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (arithmetic shift), then t_k = r_k + sign-extended offset.
  - S3 output register: t_k clamped to [-2^(DAC_DATA_WIDTH-1), 2^(DAC_DATA_WIDTH-1)-1].
  - Internal widths must not overflow before the clamp.
- Latency: a beat accepted at edge N, with the pipeline empty and m_axis_TREADY=1, appears with m_axis_TVALID=1 after edge N+4 (skid head, S1, S2, S3).
- Coefficients:
  - coefStrobe captures gainIn/offsetIn into one active register pair.
  - The new pair applies to every beat entering S1 on the edge after the strobe.
  - A beat already in S1 or later keeps its old coefficients for the offset step: offset is carried alongside the beat's data into S2.
  - All lanes of one beat always use the same pair.
- Reset/strobe priority:
  - coefStrobe during axis_RESET is ignored; reset wins.
  - satCountClear during axis_RESET has no effect beyond reset.
- Saturation count:
  - On each S3 load, satCount += number of lanes clamped (0..SAMPLES).
  - satCount sticks at 2^SAT_COUNT_WIDTH-1 and never wraps.
  - satCountClear sets satCount to 0; if a clear and an increment coincide, satCount = that increment.
- Boundary: gain = -2.0 (0x20000) times sample -32768 gives +65536, which clamps to 32767 and counts as saturated.

Test Plan:
- Passthrough: reset values; ramp lanes 0,1 / 2,3 / … / 126,127, gain 1.0, offset 0, m_axis_TREADY=1 -> output identical, first output valid 4 cycles after the first accept, one beat per clock, satCount=0.
- Rounding: gain 0x08000 (0.5), lanes {3,-3} -> {2,-1}; offset 100 -> {102,99}.
- Saturation and counter:
  - gain 0x18000 (1.5), lanes {30000,-30000} -> {32767,-32768}, satCount=2.
  - satCountClear pulsed on the same edge as another saturated beat -> satCount=2.
  - 40000 saturating beats with SAT_COUNT_WIDTH=16 -> satCount=65535.
- Backpressure: m_axis_TREADY low 1 cycle in 16 (counter pattern) plus a 20-cycle stall, upstream streaming the 0..127 ramp continuously -> s_axis_TREADY drops within 2 beats of the stall; output sequence is exactly the input ramp with no gaps or duplicates.
- Coefficient change mid-stream: coefStrobe gain 0.5 on the edge after beat 10 is accepted -> beats ≤10 are scaled by 1.0, beats ≥11 by 0.5; no beat has mixed lanes.
- Reset mid-stream: axis_RESET for 2 cycles with 3 beats in flight -> m_axis_TVALID=0 and satCount=0 next edge, coefficients back to 1.0/0, no stale beat emitted after reset; streaming resumes correctly.
